// File: rtl/coax_tx.sv
// coax_tx
// Bi-phase (Manchester) transmitter for the 3270 coax link. It takes 10-bit
// words through a one-deep holding register and frames them on the line as
// one transmission: start sequence (five "1" cells plus a code violation),
// one or more 12-bit word cells (sync, data MSB first, even parity) and an
// end sequence (one "1" cell plus two bit times of high).
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   data[9:0]    : word offered for transmission
//   load         : offer data; taken on a clock where load && ready
//   ready        : holding register can accept a word
//   active       : a frame is on the line
//   tx           : bi-phase line data
//   tx_delay     : tx delayed by CLOCKS_PER_BIT/4 clocks (pre-emphasis)
//   tx_inverted  : complement of tx while active, otherwise 0
//
// Optional feature macro: COAX_TX_DELAY_EN
//   defined   : tx_delay is tx through a CLOCKS_PER_BIT/4 stage shift register
//   undefined : tx_delay is tied to 0 and no delay register exists
module coax_tx #(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] data,
   input  logic       load,
   output logic       ready,
   output logic       active,
   output logic       tx,
   output logic       tx_delay,
   output logic       tx_inverted
);

   localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLOCKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WORD  = 2'd2;
   localparam logic [1:0] ST_END   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
   logic [3:0]       bitCnt_q, bitCnt_d;
   logic [11:0]      shift_q, shift_d;
   logic [9:0]       hold_q, hold_d;
   logic             holdFull_q, holdFull_d;
   logic             ready_q, tx_q, active_q, txInv_q;
   logic             accept, secondHalf, lastClk, txLevel, busy;

   // A word cell is sync "1", the ten data bits MSB first, then the bit that
   // makes the total number of ones in data plus parity even.
   function automatic logic [11:0] wordCell(input logic [9:0] w);
      return {1'b1, w, ^w};
   endfunction

   assign accept     = load & ready_q;
   assign secondHalf = (clkCnt_q >= HALF_CNT);
   assign lastClk    = (clkCnt_q == LAST_CNT);
   assign busy       = (state_q != ST_IDLE);

   // Line level for the clock currently being generated. The code violation
   // (low for 3H, high for 3H) is built as a full low cell, a "0" cell and a
   // full high cell, so it stays on bit-cell boundaries.
   always_comb begin
      txLevel = 1'b0;
      case (state_q)
         ST_START: begin
            if (bitCnt_q < 4'd5) begin
               txLevel = ~secondHalf;
            end else if (bitCnt_q == 4'd5) begin
               txLevel = 1'b0;
            end else if (bitCnt_q == 4'd6) begin
               txLevel = secondHalf;
            end else begin
               txLevel = 1'b1;
            end
         end
         ST_WORD: txLevel = shift_q[11] ^ secondHalf;
         ST_END:  txLevel = (bitCnt_q == 4'd0) ? ~secondHalf : 1'b1;
         default: txLevel = 1'b0;
      endcase
   end

   // Frame sequencing. A word accepted on the very last clock of a parity
   // cell goes straight into the shift register so the next sync cell
   // follows without a gap.
   always_comb begin
      state_d    = state_q;
      clkCnt_d   = lastClk ? '0 : clkCnt_q + 1'b1;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      holdFull_d = holdFull_q;
      if (accept) begin
         hold_d     = data;
         holdFull_d = 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            clkCnt_d = '0;
            bitCnt_d = '0;
            if (accept) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (lastClk) begin
               if (bitCnt_q == 4'd7) begin
                  state_d    = ST_WORD;
                  bitCnt_d   = '0;
                  shift_d    = wordCell(hold_q);
                  holdFull_d = 1'b0;
               end else begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end
            end
         end
         ST_WORD: begin
            if (lastClk) begin
               if (bitCnt_q == 4'd11) begin
                  bitCnt_d = '0;
                  if (holdFull_q) begin
                     shift_d    = wordCell(hold_q);
                     holdFull_d = 1'b0;
                  end else if (accept) begin
                     shift_d    = wordCell(data);
                     holdFull_d = 1'b0;
                  end else begin
                     state_d = ST_END;
                  end
               end else begin
                  bitCnt_d = bitCnt_q + 4'd1;
                  shift_d  = {shift_q[10:0], 1'b0};
               end
            end
         end
         ST_END: begin
            if (lastClk) begin
               if (bitCnt_q == 4'd2) begin
                  state_d  = ST_IDLE;
                  bitCnt_d = '0;
               end else begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers. Line outputs trail the sequencer by one
   // clock, which gives the one-clock start latency and makes active and tx
   // drop together on the edge after the last END clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         clkCnt_q   <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         holdFull_q <= 1'b0;
         ready_q    <= 1'b1;
         tx_q       <= 1'b0;
         active_q   <= 1'b0;
         txInv_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         clkCnt_q   <= clkCnt_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         holdFull_q <= holdFull_d;
         ready_q    <= ~holdFull_d & (state_d != ST_END);
         tx_q       <= txLevel;
         active_q   <= busy;
         txInv_q    <= busy & ~txLevel;
      end
   end

   assign ready       = ready_q;
   assign active      = active_q;
   assign tx          = tx_q;
   assign tx_inverted = txInv_q;

`ifdef COAX_TX_DELAY_EN
   localparam int DLY = CLOCKS_PER_BIT / 4;
   logic [DLY-1:0] dly_q;

   // Pre-emphasis copy of the line, a quarter bit cell behind tx.
   always_ff @(posedge clk) begin
      if (reset) begin
         dly_q <= '0;
      end else begin
         dly_q <= {dly_q[DLY-2:0], tx_q};
      end
   end

   assign tx_delay = dly_q[DLY-1];
`else
   assign tx_delay = 1'b0;
`endif

endmodule
